// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared constants, FSM states and grant ids for the two-requester RAM arbiter
package ram_arb_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic {
        GNT_A = 1'b0,
        GNT_B = 1'b1
    } grant_t;

endpackage

// File: rtl/ram_arbiter_2req_if.sv
// rtl/ram_arbiter_2req_if.sv - requester handshakes and RAM-side bus of the two-requester arbiter
interface ram_arbiter_2req_if
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic              reqA;
    logic              weA;
    logic [ADDR_W-1:0] addrA;
    logic [DATA_W-1:0] wdataA;
    logic              ackA;
    logic [DATA_W-1:0] rdataA;

    logic              reqB;
    logic              weB;
    logic [ADDR_W-1:0] addrB;
    logic [DATA_W-1:0] wdataB;
    logic              ackB;
    logic [DATA_W-1:0] rdataB;

    logic [ADDR_W-1:0] ram_Address;
    logic              ram_WE;
    logic [DATA_W-1:0] ram_inData;
    logic [DATA_W-1:0] ram_outData;

    logic              busy;

    // Arbiter side
    modport slave (
        input  reqA, weA, addrA, wdataA,
        input  reqB, weB, addrB, wdataB,
        input  ram_outData,
        output ackA, rdataA, ackB, rdataB,
        output ram_Address, ram_WE, ram_inData,
        output busy
    );

    // Requesters plus RAM side
    modport master (
        output reqA, weA, addrA, wdataA,
        output reqB, weB, addrB, wdataB,
        output ram_outData,
        input  ackA, rdataA, ackB, rdataB,
        input  ram_Address, ram_WE, ram_inData,
        input  busy
    );

endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational 2-way picker; RAM_ARB_FIXED_PRIO_EN selects strict A priority
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic   reqA,
    input  logic   reqB,
    input  grant_t last_grant,
    output logic   gnt_valid,
    output grant_t gnt_id
);

`ifdef RAM_ARB_FIXED_PRIO_EN
    // Strict priority ignores history
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    // Pick a winner; on a tie alternate (or favour A under strict priority)
    always_comb begin
        gnt_valid = reqA | reqB;
        gnt_id    = GNT_A;
`ifdef RAM_ARB_FIXED_PRIO_EN
        if (!reqA && reqB) begin
            gnt_id = GNT_B;
        end
`else
        if (reqA && reqB) begin
            gnt_id = (last_grant == GNT_A) ? GNT_B : GNT_A;
        end else if (reqB) begin
            gnt_id = GNT_B;
        end
`endif
    end

endmodule

// File: rtl/ram_arbiter_2req.sv
// rtl/ram_arbiter_2req.sv - shares one 32x8 RAM between requesters A and B (optional RAM_ARB_FIXED_PRIO_EN)
module ram_arbiter_2req
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
)(
    input  logic              Clock,
    input  logic              Reset,
    ram_arbiter_2req_if.slave bus
);

    state_t            state;
    state_t            state_next;
    grant_t            last_grant;
    grant_t            gnt_q;
    logic              we_q;

    logic              gnt_valid;
    grant_t            gnt_id;
    logic              take_grant;
    logic              finish;

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              ram_we_q;
    logic              ack_a_q;
    logic              ack_b_q;
    logic [DATA_W-1:0] rdata_a_q;
    logic [DATA_W-1:0] rdata_b_q;

    rr_arb2 u_pick (
        .reqA       (bus.reqA),
        .reqB       (bus.reqB),
        .last_grant (last_grant),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    // State register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: requests are only looked at in IDLE, every access takes SERVE then DONE
    always_comb begin
        state_next = state;
        take_grant = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_valid) begin
                    take_grant = 1'b1;
                    state_next = SERVE;
                end
            end
            SERVE: begin
                finish     = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Latch the winner's access onto the RAM bus, then complete it with an ack pulse
    always_ff @(posedge Clock) begin
        if (Reset) begin
            last_grant <= GNT_B;
            gnt_q      <= GNT_A;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ram_we_q   <= 1'b0;
            ack_a_q    <= 1'b0;
            ack_b_q    <= 1'b0;
            rdata_a_q  <= '0;
            rdata_b_q  <= '0;
        end else begin
            ack_a_q  <= 1'b0;
            ack_b_q  <= 1'b0;
            ram_we_q <= 1'b0;
            if (take_grant) begin
                gnt_q      <= gnt_id;
                last_grant <= gnt_id;
                if (gnt_id == GNT_A) begin
                    we_q     <= bus.weA;
                    ram_we_q <= bus.weA;
                    addr_q   <= bus.addrA;
                    wdata_q  <= bus.wdataA;
                end else begin
                    we_q     <= bus.weB;
                    ram_we_q <= bus.weB;
                    addr_q   <= bus.addrB;
                    wdata_q  <= bus.wdataB;
                end
            end
            if (finish) begin
                ack_a_q <= (gnt_q == GNT_A);
                ack_b_q <= (gnt_q == GNT_B);
                if (!we_q) begin
                    if (gnt_q == GNT_A) begin
                        rdata_a_q <= bus.ram_outData;
                    end else begin
                        rdata_b_q <= bus.ram_outData;
                    end
                end
            end
        end
    end

    assign bus.ram_Address = addr_q;
    assign bus.ram_inData  = wdata_q;
    assign bus.ram_WE      = ram_we_q;
    assign bus.ackA        = ack_a_q;
    assign bus.ackB        = ack_b_q;
    assign bus.rdataA      = rdata_a_q;
    assign bus.rdataB      = rdata_b_q;
    assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_ram_arbiter_2req.sv
// tb/tb_ram_arbiter_2req.sv - self-checking bench for ram_arbiter_2req with a behavioural access model
module tb_ram_arbiter_2req;
    import ram_arb_pkg::*;

    localparam int AW = 5;
    localparam int DW = 8;

    logic Clock = 1'b0;
    logic Reset;

    int checks = 0;
    int errors = 0;

    ram_arbiter_2req_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ram_arbiter_2req #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    // The RAM itself: synchronous write, combinational read
    logic [DW-1:0] ram_mem [32] = '{default: '0};
    assign bus.ram_outData = ram_mem[bus.ram_Address];
    always @(posedge Clock) begin
        if (bus.ram_WE) ram_mem[bus.ram_Address] <= bus.ram_inData;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // An access granted at cycle g drives the RAM during cycle g, completes at edge g+1
    // (ack visible the following cycle) and frees the arbiter at edge g+2.
    logic [DW-1:0] m_mem [32] = '{default: '0};
    bit            m_on = 0;
    bit            m_active = 0;
    int            cyc = 0;
    int            m_start = 0;
    bit            m_last_b = 1;
    bit            m_gnt_b;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd;
    logic          e_ack_a = 0, e_ack_b = 0, e_we = 0, e_busy = 0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_wd = '0, e_rd_a = '0, e_rd_b = '0;

    function automatic bit pick_b(input logic ra, input logic rb, input bit last_b);
        if (ra && rb) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
            return 1'b0;
`else
            return !last_b;
`endif
        end
        return rb;
    endfunction

    initial begin
        forever begin
            @(posedge Clock);
            cyc++;
            if (Reset) begin
                if (m_active && (cyc - m_start == 1) && m_we) m_mem[m_addr] = m_wd;
                m_on = 1; m_active = 0; m_last_b = 1;
                e_ack_a = 0; e_ack_b = 0; e_we = 0; e_busy = 0;
                e_addr = '0; e_wd = '0; e_rd_a = '0; e_rd_b = '0;
            end else if (m_active) begin
                if (cyc - m_start == 1) begin
                    if (m_we) m_mem[m_addr] = m_wd;
                    else if (m_gnt_b) e_rd_b = m_mem[m_addr];
                    else e_rd_a = m_mem[m_addr];
                    e_ack_a = !m_gnt_b; e_ack_b = m_gnt_b; e_we = 0;
                end else begin
                    e_ack_a = 0; e_ack_b = 0; e_busy = 0; m_active = 0;
                end
            end else begin
                e_ack_a = 0; e_ack_b = 0; e_we = 0;
                if (bus.reqA || bus.reqB) begin
                    m_gnt_b  = pick_b(bus.reqA, bus.reqB, m_last_b);
                    m_last_b = m_gnt_b;
                    m_we     = m_gnt_b ? bus.weB : bus.weA;
                    m_addr   = m_gnt_b ? bus.addrB : bus.addrA;
                    m_wd     = m_gnt_b ? bus.wdataB : bus.wdataA;
                    m_active = 1; m_start = cyc;
                    e_we = m_we; e_addr = m_addr; e_wd = m_wd; e_busy = 1;
                end
            end
        end
    end

    // Per-cycle comparison against the model
    initial begin
        forever begin
            @(negedge Clock);
            if (m_on) begin
                check("ackA", bus.ackA, e_ack_a);
                check("ackB", bus.ackB, e_ack_b);
                check("rdataA", bus.rdataA, e_rd_a);
                check("rdataB", bus.rdataB, e_rd_b);
                check("ram_WE", bus.ram_WE, e_we);
                check("ram_Address", bus.ram_Address, e_addr);
                check("ram_inData", bus.ram_inData, e_wd);
                check("busy", bus.busy, e_busy);
            end
        end
    end

    // Grant-order log and write-strobe monitor
    int            order_q[$];
    int            we_cnt = 0;
    logic [AW-1:0] we_addr = '0;
    initial begin
        forever begin
            @(negedge Clock);
            if (bus.ackA === 1'b1) order_q.push_back(0);
            if (bus.ackB === 1'b1) order_q.push_back(1);
            if (bus.ram_WE === 1'b1) begin
                we_cnt++;
                we_addr = bus.ram_Address;
            end
        end
    end

    task automatic access(input bit who, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, output logic [DW-1:0] rd, output int lat);
        bit got;
        @(negedge Clock);
        if (who) begin
            bus.weB = we; bus.addrB = a; bus.wdataB = d; bus.reqB = 1'b1;
        end else begin
            bus.weA = we; bus.addrA = a; bus.wdataA = d; bus.reqA = 1'b1;
        end
        lat = 0;
        got = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clock);
            lat++;
            if ((who ? bus.ackB : bus.ackA) === 1'b1) begin
                got = 1;
                break;
            end
        end
        if (!got) check(who ? "ackB_timeout" : "ackA_timeout", 32'd0, 32'd1);
        rd = who ? bus.rdataB : bus.rdataA;
        if (who) bus.reqB = 1'b0;
        else bus.reqA = 1'b0;
    endtask

    logic [DW-1:0] rd_a, rd_b;
    int            lat_a, lat_b;

    task automatic random_requester(input bit who);
        logic [DW-1:0] rd;
        int            lat;
        repeat (40) begin
            repeat ($urandom_range(0, 3)) @(negedge Clock);
            access(who, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)),
                   DW'($urandom_range(0, 255)), rd, lat);
        end
    endtask

    initial begin
        bus.reqA = 0; bus.weA = 0; bus.addrA = '0; bus.wdataA = '0;
        bus.reqB = 0; bus.weB = 0; bus.addrB = '0; bus.wdataB = '0;
        Reset = 1;
        repeat (2) @(negedge Clock);
        check("rst_ackA", bus.ackA, 0);
        check("rst_ackB", bus.ackB, 0);
        check("rst_rdataA", bus.rdataA, 0);
        check("rst_rdataB", bus.rdataB, 0);
        check("rst_ram_WE", bus.ram_WE, 0);
        check("rst_ram_Address", bus.ram_Address, 0);
        check("rst_busy", bus.busy, 0);
        Reset = 0;

        // A writes 100 @10, then reads it back
        we_cnt = 0;
        access(0, 1, 10, 100, rd_a, lat_a);
        check("wrA_latency", lat_a, 2);
        check("wrA_we_cycles", we_cnt, 1);
        check("wrA_we_addr", we_addr, 10);
        access(0, 0, 10, 0, rd_a, lat_a);
        check("rdA_addr10", rd_a, 100);
        access(1, 0, 10, 0, rd_b, lat_b);
        check("rdB_addr10", rd_b, 100);

        // Simultaneous writes: A wins the tie
        order_q.delete();
        fork
            access(0, 1, 0, 1, rd_a, lat_a);
            access(1, 1, 1, 5, rd_b, lat_b);
        join
        check("tie_count", order_q.size(), 2);
        if (order_q.size() == 2) begin
            check("tie_first", order_q[0], 0);
            check("tie_second", order_q[1], 1);
        end
        access(0, 0, 0, 0, rd_a, lat_a);
        check("rd_mem0", rd_a, 1);
        access(1, 0, 1, 0, rd_b, lat_b);
        check("rd_mem1", rd_b, 5);
        check("model_mem0", m_mem[0], 1);

        // Both requesters keep asking: three accesses each
        order_q.delete();
        fork
            begin
                repeat (3) access(0, 0, 0, 0, rd_a, lat_a);
            end
            begin
                repeat (3) access(1, 0, 1, 0, rd_b, lat_b);
            end
        join
        check("fair_count", order_q.size(), 6);
        if (order_q.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
                check("prio_order", order_q[i], (i < 3) ? 0 : 1);
`else
                check("fair_order", order_q[i], i % 2);
`endif
            end
        end

        // B overwrites addr 10, A reads the new value, B's read data is untouched
        access(1, 1, 10, 10, rd_b, lat_b);
        access(0, 0, 10, 0, rd_a, lat_a);
        check("overwrite_rdA", rd_a, 10);
        check("isolation_rdB", bus.rdataB, 5);

        // Reset while a write is in SERVE
        @(negedge Clock);
        bus.weA = 1; bus.addrA = 3; bus.wdataA = 55; bus.reqA = 1;
        @(negedge Clock);
        check("midrst_we_in_serve", bus.ram_WE, 1);
        Reset = 1;
        @(negedge Clock);
        check("midrst_ackA", bus.ackA, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_ram_WE", bus.ram_WE, 0);
        bus.reqA = 0;
        Reset = 0;
        @(negedge Clock);
        check("midrst_no_late_ack", bus.ackA, 0);
        check("midrst_idle", bus.busy, 0);

        // Randomised traffic from both sides
        fork
            random_requester(0);
            random_requester(1);
        join
        repeat (4) @(negedge Clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_arbiter_2req.md
Name: ram_arbiter_2req

Overview:
- Shares the single-port 32 x 8 RAM (synchronous write, combinational read) between two requesters, A and B.
- Each requester uses a req/ack handshake. The block multiplexes address, write enable and write data onto the RAM, and returns registered read data.
- Sits between two datapath masters (for example a load/store unit and a DMA-style loader) and the RAM instance.

Parameters:
- ADDR_W, 5, RAM address width (32 locations).
- DATA_W, 8, RAM data width.

Ports:
- Clock  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- reqA  in  1  requester A access request; held high until ackA.
- weA  in  1  A: 1 = write, 0 = read; stable while reqA is high.
- addrA  in  ADDR_W  A address; stable while reqA is high.
- wdataA  in  DATA_W  A write data; stable while reqA is high.
- ackA  out  1  one-cycle completion pulse to A.
- rdataA  out  DATA_W  A read data; valid when ackA=1 for a read.
- reqB, weB, addrB, wdataB, ackB, rdataB  same as the A ports, for requester B.
- ram_Address  out  ADDR_W  to RAM Address.
- ram_WE  out  1  to RAM WE.
- ram_inData  out  DATA_W  to RAM inData.
- ram_outData  in  DATA_W  from RAM outData.
- busy  out  1  high in SERVE or DONE.

Behaviour:
- Reset (synchronous): state=IDLE, ackA=ackB=0, ram_WE=0, ram_Address=0, ram_inData=0, rdataA=rdataB=0, last_grant=B (so A wins the first tie).
- FSM states: IDLE -> SERVE -> DONE -> IDLE.
- IDLE: sample reqA/reqB at the clock edge.
  - Neither request: stay in IDLE.
  - Only one request: grant it.
  - Both requests: grant the requester that is not last_grant.
  - On a grant: latch grant id, we, addr and wdata into internal registers; update last_grant; go to SERVE.
- SERVE (1 cycle):
  - ram_Address = latched addr; ram_inData = latched wdata; ram_WE = latched we.
  - At the closing edge, a write commits in the RAM. A read captures ram_outData into the granted requester's rdata register; the other rdata register holds its value.
  - Next state is DONE.
- DONE (1 cycle):
  - Granted requester's ack=1; ram_WE=0.
  - Next state is IDLE.
- ram_Address/ram_inData outputs are registered. ram_WE is high only during SERVE of a write, never in IDLE or DONE.
- Latency: grant edge to ack = 2 cycles. Throughput: 1 access per 3 cycles.
- Handshake rule: a requester drops req in the cycle after it sees ack. Because IDLE follows DONE, a dropped req is never re-granted. A req still high in IDLE is treated as a new access.
- rdata holds its value until that requester's next read completes. Writes leave rdata unchanged.
- A req arriving while busy waits; the FSM samples only in IDLE.
- Reset mid-operation:
  - In SERVE with a write: reset takes priority and ram_WE is driven 0 from the reset edge. Whether the write committed depends only on edges already past.
  - No ack is issued for an aborted access.
- Address wrap does not apply; addresses are used as given (0..31).

Optional Feature:
- Macro: RAM_ARB_FIXED_PRIO_EN.
- Defined: A always wins when both request (strict priority); last_grant is not used. B can starve while A keeps requesting.
- Undefined (default): round-robin as in Behaviour.

Decomposition:
- Package ram_arb_pkg holds:
  - ADDR_W/DATA_W default constants.
  - State enum {IDLE, SERVE, DONE}.
  - Grant-id typedef (GNT_A=0, GNT_B=1).
- Sub-module rr_arb2: combinational 2-way picker.
  - Inputs: reqA, reqB, last_grant. Outputs: gnt_valid, gnt_id.
  - Contains the RAM_ARB_FIXED_PRIO_EN switch.
- The FSM and datapath registers live in ram_arbiter_2req.

Test Plan:
- Reset: assert Reset 2 cycles -> all outputs 0, busy=0, ram_WE=0.
- Single write then read (A):
  - A writes 8'd100 to addr 10 -> ackA 2 cycles after the grant edge; ram_WE high exactly 1 cycle with ram_Address=10.
  - A then reads addr 10 -> rdataA=100 with ackA.
- Simultaneous requests:
  - reqA (write 8'd1 @0) and reqB (write 8'd5 @1) in the same cycle -> A served first, then B.
  - Reads return mem[0]=1, mem[1]=5.
- Round-robin fairness: A and B hold req continuously for 6 accesses -> grant order A,B,A,B,A,B; each ack is a single-cycle pulse.
- Overwrite/isolation: B writes 8'd10 over addr 10 (held 100), then A reads addr 10 -> rdataA=10; rdataB unchanged.
- Reset mid-SERVE: A writes 8'd55 @3 and Reset is asserted in SERVE -> no ackA, state=IDLE next cycle, ram_WE=0.
- With RAM_ARB_FIXED_PRIO_EN defined: repeat the fairness scenario -> A granted every time while reqA is held; B is served only after reqA drops.
